// File: rtl/envm_fault_map_ctrl.sv
// Embedded-NVM model for systolic-array self-test: scan pattern store with
// registered reads, counted fault-capture sessions and a popcounted fault map.
module envm_fault_map_ctrl #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int SA_DEPTH          = 12,
  parameter int TD_DEPTH          = 18,
  parameter int PAT_ADDR_WIDTH    = $clog2((SA_DEPTH > TD_DEPTH) ? SA_DEPTH : TD_DEPTH),
  parameter int ROW_WIDTH         = $clog2(SYSTOLIC_SIZE),
  parameter int CNT_WIDTH         = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE + 1),
  parameter int PAT_WIDTH         = WEIGHT_WIDTH + ACTIVATION_WIDTH + PARTIAL_SUM_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pat_wr_en,
  input  logic                                   pat_wr_type,
  input  logic [PAT_ADDR_WIDTH-1:0]              pat_wr_addr,
  input  logic [PAT_WIDTH-1:0]                   pat_wr_data,
  input  logic                                   pat_rd_en,
  input  logic                                   pat_rd_type,
  input  logic [PAT_ADDR_WIDTH-1:0]              pat_rd_addr,
  output logic                                   pat_rd_valid,
  output logic [WEIGHT_WIDTH-1:0]                scan_data_weight,
  output logic [ACTIVATION_WIDTH-1:0]            scan_data_activation,
  output logic [PARTIAL_SUM_WIDTH-1:0]           scan_data_answer,
  output logic                                   pat_err,
  input  logic                                   det_start,
  input  logic                                   det_merge,
  input  logic                                   det_valid,
  input  logic [SYSTOLIC_SIZE-1:0]               single_pe_detection,
  input  logic                                   row_fault_detection,
  input  logic                                   column_fault_detection,
  input  logic                                   map_clear,
  output logic                                   busy,
  output logic                                   det_done,
  output logic [CNT_WIDTH-1:0]                   fault_count,
  output logic [SYSTOLIC_SIZE-1:0]               faulty_row_vec,
  output logic [SYSTOLIC_SIZE-1:0]               faulty_col_vec,
  output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat
);

  localparam int SA_AW = (SA_DEPTH > 1) ? $clog2(SA_DEPTH) : 1;
  localparam int TD_AW = (TD_DEPTH > 1) ? $clog2(TD_DEPTH) : 1;
  localparam logic [PAT_ADDR_WIDTH-1:0] SA_LIM   = PAT_ADDR_WIDTH'(SA_DEPTH);
  localparam logic [PAT_ADDR_WIDTH-1:0] TD_LIM   = PAT_ADDR_WIDTH'(TD_DEPTH);
  localparam logic [ROW_WIDTH-1:0]      ROW_LAST = ROW_WIDTH'(SYSTOLIC_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_COUNT, S_DONE} state_t;

  // ---------------- pattern store (not reset: NVM contents persist) -------
  logic [PAT_WIDTH-1:0] sa_mem [SA_DEPTH];
  logic [PAT_WIDTH-1:0] td_mem [TD_DEPTH];

  logic wr_oor, rd_oor;
  logic [PAT_WIDTH-1:0] rd_word;
  logic                 rd_valid_d, rd_valid_q, pat_err_d, pat_err_q;
  logic [PAT_WIDTH-1:0] scan_d, scan_q;

  assign wr_oor = pat_wr_type ? (pat_wr_addr >= TD_LIM) : (pat_wr_addr >= SA_LIM);
  assign rd_oor = pat_rd_type ? (pat_rd_addr >= TD_LIM) : (pat_rd_addr >= SA_LIM);

  always_ff @(posedge clk) begin
    if (pat_wr_en && !wr_oor) begin
      if (pat_wr_type) td_mem[TD_AW'(pat_wr_addr)] <= pat_wr_data;
      else             sa_mem[SA_AW'(pat_wr_addr)] <= pat_wr_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (!rd_oor)
      rd_word = pat_rd_type ? td_mem[TD_AW'(pat_rd_addr)] : sa_mem[SA_AW'(pat_rd_addr)];
    scan_d     = pat_rd_en ? rd_word : scan_q;
    rd_valid_d = pat_rd_en;
    pat_err_d  = (pat_wr_en && wr_oor) || (pat_rd_en && rd_oor);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q     <= '0;
      rd_valid_q <= 1'b0;
      pat_err_q  <= 1'b0;
    end else begin
      scan_q     <= scan_d;
      rd_valid_q <= rd_valid_d;
      pat_err_q  <= pat_err_d;
    end
  end

  assign pat_rd_valid         = rd_valid_q;
  assign pat_err              = pat_err_q;
  assign scan_data_weight     = scan_q[PAT_WIDTH-1 -: WEIGHT_WIDTH];
  assign scan_data_activation = scan_q[PARTIAL_SUM_WIDTH +: ACTIVATION_WIDTH];
  assign scan_data_answer     = scan_q[PARTIAL_SUM_WIDTH-1:0];

  // ---------------- capture / count session -------------------------------
  state_t                                   state_d, state_q;
  logic [ROW_WIDTH-1:0]                     row_d, row_q;
  logic                                     merge_d, merge_q;
  logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0] map_d, map_q;
  logic [SYSTOLIC_SIZE-1:0]                 rowv_d, rowv_q, colv_d, colv_q;
  logic [CNT_WIDTH-1:0]                     acc_d, acc_q, cnt_d, cnt_q;
  logic [CNT_WIDTH-1:0]                     row_pop;

  function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [SYSTOLIC_SIZE-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) c = c + CNT_WIDTH'(v[i]);
    return c;
  endfunction

  assign row_pop = popcnt(map_q[row_q]);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    merge_d = merge_q;
    map_d   = map_q;
    rowv_d  = rowv_q;
    colv_d  = colv_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (map_clear) begin
          map_d  = '0;
          rowv_d = '0;
          colv_d = '0;
          cnt_d  = '0;
        end
        if (det_start) begin
          state_d = S_CAPTURE;
          row_d   = '0;
          merge_d = det_merge;
        end
      end
      S_CAPTURE: begin
        if (det_valid) begin
          // Merge keeps previously recorded faults; overwrite replaces the row.
          map_d[row_q]  = single_pe_detection    | (merge_q ? map_q[row_q]  : '0);
          rowv_d[row_q] = row_fault_detection    | (merge_q & rowv_q[row_q]);
          colv_d[row_q] = column_fault_detection | (merge_q & colv_q[row_q]);
          row_d = row_q + 1'b1;
          if (row_q == ROW_LAST) begin
            state_d = S_COUNT;
            row_d   = '0;
            acc_d   = '0;
          end
        end
      end
      S_COUNT: begin
        acc_d = acc_q + row_pop;
        row_d = row_q + 1'b1;
        if (row_q == ROW_LAST) begin
          cnt_d   = acc_q + row_pop;
          row_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      merge_q <= 1'b0;
      map_q   <= '0;
      rowv_q  <= '0;
      colv_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      merge_q <= merge_d;
      map_q   <= map_d;
      rowv_q  <= rowv_d;
      colv_q  <= colv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy                      = (state_q == S_CAPTURE) || (state_q == S_COUNT);
  assign det_done                  = (state_q == S_DONE);
  assign fault_count               = cnt_q;
  assign faulty_row_vec            = rowv_q;
  assign faulty_col_vec            = colv_q;
  assign envm_faulty_patterns_flat = map_q;

endmodule

// File: tb/tb_envm_fault_map_ctrl.sv
// Directed bench for envm_fault_map_ctrl: pattern store access and
// overwrite/merge capture sessions with hand-computed expectations.
module tb_envm_fault_map_ctrl;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pat_wr_en = 0, pat_wr_type = 0, pat_rd_en = 0, pat_rd_type = 0;
  logic [4:0]  pat_wr_addr = '0, pat_rd_addr = '0;
  logic [34:0] pat_wr_data = '0;
  logic        pat_rd_valid, pat_err, busy, det_done;
  logic [7:0]  scan_data_weight, scan_data_activation;
  logic [18:0] scan_data_answer;
  logic        det_start = 0, det_merge = 0, det_valid = 0, map_clear = 0;
  logic [7:0]  single_pe_detection = '0;
  logic        row_fault_detection = 0, column_fault_detection = 0;
  logic [6:0]  fault_count;
  logic [7:0]  faulty_row_vec, faulty_col_vec;
  logic [63:0] envm_faulty_patterns_flat;

  int n_cmp = 0, n_bad = 0;

  envm_fault_map_ctrl dut (
    .clk(clk), .rst(rst),
    .pat_wr_en(pat_wr_en), .pat_wr_type(pat_wr_type), .pat_wr_addr(pat_wr_addr),
    .pat_wr_data(pat_wr_data), .pat_rd_en(pat_rd_en), .pat_rd_type(pat_rd_type),
    .pat_rd_addr(pat_rd_addr), .pat_rd_valid(pat_rd_valid),
    .scan_data_weight(scan_data_weight), .scan_data_activation(scan_data_activation),
    .scan_data_answer(scan_data_answer), .pat_err(pat_err),
    .det_start(det_start), .det_merge(det_merge), .det_valid(det_valid),
    .single_pe_detection(single_pe_detection), .row_fault_detection(row_fault_detection),
    .column_fault_detection(column_fault_detection), .map_clear(map_clear),
    .busy(busy), .det_done(det_done), .fault_count(fault_count),
    .faulty_row_vec(faulty_row_vec), .faulty_col_vec(faulty_col_vec),
    .envm_faulty_patterns_flat(envm_faulty_patterns_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input logic m, input logic [7:0][7:0] pe,
                             input logic [7:0] rf, input logic [7:0] cf,
                             input logic interfere);
    det_start = 1; det_merge = m;
    tick;
    det_start = 0; det_merge = 0;
    chk("busy_capture", busy, 1);
    for (int r = 0; r < N; r++) begin
      det_valid = 1; single_pe_detection = pe[r];
      row_fault_detection = rf[r]; column_fault_detection = cf[r];
      tick;
    end
    det_valid = 0; single_pe_detection = '0;
    row_fault_detection = 0; column_fault_detection = 0;
    for (int k = 1; k <= N - 1; k++) begin
      if (interfere && k == 3) begin det_start = 1; map_clear = 1; end
      tick;
      det_start = 0; map_clear = 0;
    end
    chk("done_early", det_done, 0);
    chk("busy_count", busy, 1);
    tick;
    chk("det_done", det_done, 1);
    chk("busy_done", busy, 0);
  endtask

  task automatic back_to_idle;
    tick;
    chk("done_clr", det_done, 0);
    chk("busy_idle", busy, 0);
  endtask

  logic [7:0][7:0] pe;

  initial begin
    repeat (2) tick;
    chk("rst_valid", pat_rd_valid, 0);
    chk("rst_err", pat_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", det_done, 0);
    chk("rst_cnt", fault_count, 0);
    chk("rst_flat", envm_faulty_patterns_flat, 0);
    chk("rst_scan", {scan_data_weight, scan_data_activation, scan_data_answer}, 0);
    rst = 0;
    tick;

    // SA 3 write then read back
    pat_wr_en = 1; pat_wr_type = 0; pat_wr_addr = 3; pat_wr_data = {8'h5A, 8'hC3, 19'h01234};
    tick;
    pat_wr_en = 0;
    chk("wr_err", pat_err, 0);
    pat_rd_en = 1; pat_rd_type = 0; pat_rd_addr = 3;
    tick;
    pat_rd_en = 0;
    chk("rd_valid", pat_rd_valid, 1);
    chk("rd_w", scan_data_weight, 8'h5A);
    chk("rd_a", scan_data_activation, 8'hC3);
    chk("rd_ans", scan_data_answer, 19'h01234);
    chk("rd_err", pat_err, 0);
    tick;
    chk("rd_valid_pulse", pat_rd_valid, 0);
    chk("rd_hold", scan_data_weight, 8'h5A);

    // out-of-range SA write, TD 17 in range
    pat_wr_en = 1; pat_wr_type = 0; pat_wr_addr = 12; pat_wr_data = 35'h7_FFFF_FFFF;
    tick;
    pat_wr_en = 0;
    chk("wr_oor_err", pat_err, 1);
    pat_wr_en = 1; pat_wr_type = 1; pat_wr_addr = 17; pat_wr_data = {8'hA5, 8'h3C, 19'h7ABCD};
    tick;
    pat_wr_en = 0;
    chk("err_pulse", pat_err, 0);
    pat_rd_en = 1; pat_rd_type = 1; pat_rd_addr = 17;
    tick;
    chk("td17_w", scan_data_weight, 8'hA5);
    chk("td17_ans", scan_data_answer, 19'h7ABCD);
    chk("td17_err", pat_err, 0);
    pat_rd_type = 0; pat_rd_addr = 12;
    tick;
    pat_rd_en = 0;
    chk("rd_oor_valid", pat_rd_valid, 1);
    chk("rd_oor_data", {scan_data_weight, scan_data_activation, scan_data_answer}, 0);
    chk("rd_oor_err", pat_err, 1);

    // same-cycle write and read of SA 3 returns the old word
    pat_wr_en = 1; pat_wr_type = 0; pat_wr_addr = 3; pat_wr_data = {8'h11, 8'h22, 19'h00033};
    pat_rd_en = 1; pat_rd_type = 0; pat_rd_addr = 3;
    tick;
    pat_wr_en = 0;
    chk("rdw_old", scan_data_weight, 8'h5A);
    tick;
    pat_rd_en = 0;
    chk("rdw_new", scan_data_weight, 8'h11);

    // det_valid while idle is ignored
    det_valid = 1; single_pe_detection = 8'hFF;
    tick;
    det_valid = 0; single_pe_detection = '0;
    chk("idle_valid", envm_faulty_patterns_flat, 0);

    // S1: overwrite
    pe = '0; pe[2] = 8'h81; pe[5] = 8'h01;
    run_session(0, pe, 8'h04, 8'h80, 0);
    chk("s1_cnt", fault_count, 3);
    chk("s1_rowv", faulty_row_vec, 8'h04);
    chk("s1_colv", faulty_col_vec, 8'h80);
    chk("s1_row2", envm_faulty_patterns_flat[23:16], 8'h81);
    chk("s1_flat", envm_faulty_patterns_flat, 64'h0000_0100_0081_0000);
    back_to_idle;

    // S2: merge
    pe = '0; pe[5] = 8'h02;
    run_session(1, pe, 8'h00, 8'h00, 0);
    chk("s2_cnt", fault_count, 4);
    chk("s2_row5", envm_faulty_patterns_flat[47:40], 8'h03);
    chk("s2_rowv", faulty_row_vec, 8'h04);
    chk("s2_colv", faulty_col_vec, 8'h80);
    back_to_idle;

    // S3: zero merge with det_start/map_clear during COUNT
    pe = '0;
    run_session(1, pe, 8'h00, 8'h00, 1);
    chk("s3_cnt", fault_count, 4);
    chk("s3_flat", envm_faulty_patterns_flat, 64'h0000_0300_0081_0000);
    back_to_idle;

    // map_clear in IDLE
    map_clear = 1;
    tick;
    map_clear = 0;
    chk("clr_cnt", fault_count, 0);
    chk("clr_flat", envm_faulty_patterns_flat, 0);
    chk("clr_vec", {faulty_row_vec, faulty_col_vec}, 0);

    // S4 then all-zero overwrite
    pe = '0; pe[1] = 8'hFF; pe[0] = 8'h10;
    run_session(0, pe, 8'h02, 8'h01, 0);
    chk("s4_cnt", fault_count, 9);
    back_to_idle;
    pe = '0;
    run_session(0, pe, 8'h00, 8'h00, 0);
    chk("s5_cnt", fault_count, 0);
    chk("s5_flat", envm_faulty_patterns_flat, 0);
    chk("s5_rowv", faulty_row_vec, 0);
    back_to_idle;
    pe = '0; pe[1] = 8'hFF; pe[0] = 8'h10;
    run_session(0, pe, 8'h02, 8'h01, 0);
    chk("s4b_cnt", fault_count, 9);
    back_to_idle;

    // reset after 3 capture beats
    det_start = 1;
    tick;
    det_start = 0;
    for (int r = 0; r < 3; r++) begin
      det_valid = 1; single_pe_detection = 8'hFF; row_fault_detection = 1;
      tick;
    end
    det_valid = 0; single_pe_detection = '0; row_fault_detection = 0;
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_flat", envm_faulty_patterns_flat, 0);
    chk("arst_cnt", fault_count, 0);
    tick;
    rst = 0;
    tick;
    pat_rd_en = 1; pat_rd_type = 1; pat_rd_addr = 17;
    tick;
    pat_rd_en = 0;
    chk("nvm_keep", {scan_data_weight, scan_data_activation, scan_data_answer},
        {29'd0, 8'hA5, 8'h3C, 19'h7ABCD});
    chk("nvm_valid", pat_rd_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
